// File: rtl/wb_mem_tester_pkg.sv
// Shared types and LFSR step function for the Wishbone memory self-test master.
package wb_mem_tester_pkg;

  typedef enum logic [2:0] {IDLE, WR, WGAP, RD, RGAP, FIN} state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/wb_mem_tester_if.sv
// Wishbone classic bus between the self-test master and a memory slave.
interface wb_mem_tester_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]            wb_sel_o;
  logic [31:0]           wb_dat_o;
  logic [31:0]           wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/wb_mem_tester_lfsr32.sv
// 32-bit Galois LFSR pattern source; load has priority over advance.
module lfsr32
  import wb_mem_tester_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2345
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        adv_i,
  output logic [31:0] q_o
);

  logic [31:0] r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_q <= SEED;
    else if (load_i) r_q <= seed_i;
    else if (adv_i)  r_q <= lfsr_next(r_q);
  end

  assign q_o = r_q;

endmodule

// File: rtl/wb_mem_tester.sv
// Wishbone classic BIST master: writes an LFSR pattern over a word window, reads it back and compares.
// Optional WB_MEM_TESTER_ERR_LOG_EN adds capture of the first failing address/expected/actual word.
module wb_mem_tester
  import wb_mem_tester_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    WORDS      = 64,
  parameter int                    TIMEOUT    = 255,
  parameter logic [31:0]           SEED       = 32'hACE1_2345
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [15:0]           err_count_o,
  wb_mem_tester_if.master       wb
`ifdef WB_MEM_TESTER_ERR_LOG_EN
  ,
  output logic [ADDR_WIDTH-1:0] first_err_adr_o,
  output logic [31:0]           first_err_exp_o,
  output logic [31:0]           first_err_act_o
`endif
);

  localparam int             IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int             TW   = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0]  LAST = IW'(WORDS - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                r_state, w_next;
  logic [IW-1:0]         r_idx;
  logic [TW-1:0]         r_tmo;
  logic [15:0]           r_err;
  logic                  r_pass, r_timeout;
  logic [31:0]           w_lfsr;
  logic                  w_stb, w_xfer, w_bad, w_tmo_hit, w_last, w_load;
  logic [ADDR_WIDTH-1:0] w_adr;

  assign w_stb     = (r_state == WR) || (r_state == RD);
  assign w_xfer    = w_stb && (wb.wb_ack_i || wb.wb_err_i);
  // ERR wins over ACK; a read ACK is only checked when ERR is low.
  assign w_bad     = w_xfer && (wb.wb_err_i || ((r_state == RD) && (wb.wb_dat_i != w_lfsr)));
  assign w_tmo_hit = w_stb && !w_xfer && (r_tmo == TW'(TIMEOUT - 1));
  assign w_last    = (r_idx == LAST);
  assign w_load    = ((r_state == IDLE) && start_i) || ((r_state == WGAP) && w_last);
  assign w_adr     = BASE_ADDR + ADDR_WIDTH'({r_idx, 2'b00});

  lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (w_load),
    .seed_i (SEED),
    .adv_i  (w_xfer),
    .q_o    (w_lfsr)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_next = WR;
      WR:      if (w_xfer) w_next = WGAP; else if (w_tmo_hit) w_next = FIN;
      WGAP:    w_next = w_last ? RD : WR;
      RD:      if (w_xfer) w_next = RGAP; else if (w_tmo_hit) w_next = FIN;
      RGAP:    w_next = w_last ? FIN : RD;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_tmo     <= '0;
      r_err     <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tmo   <= (w_stb && !w_xfer) ? r_tmo + 1'b1 : '0;
      case (r_state)
        IDLE: if (start_i) begin
          r_err     <= '0;
          r_timeout <= 1'b0;
          r_pass    <= 1'b0;
          r_idx     <= '0;
        end
        WR, RD: begin
          if (w_bad)     r_err     <= sat_inc(r_err);
          if (w_tmo_hit) r_timeout <= 1'b1;
        end
        WGAP, RGAP: r_idx <= w_last ? '0 : r_idx + 1'b1;
        FIN:        r_pass <= (r_err == 16'd0) && !r_timeout;
        default: ;
      endcase
    end
  end

`ifdef WB_MEM_TESTER_ERR_LOG_EN
  logic                  r_logged;
  logic [ADDR_WIDTH-1:0] r_fe_adr;
  logic [31:0]           r_fe_exp, r_fe_act;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_logged <= 1'b0;
      r_fe_adr <= '0;
      r_fe_exp <= '0;
      r_fe_act <= '0;
    end else if ((r_state == IDLE) && start_i) begin
      r_logged <= 1'b0;
      r_fe_adr <= '0;
      r_fe_exp <= '0;
      r_fe_act <= '0;
    end else if (w_bad && !r_logged) begin
      r_logged <= 1'b1;
      r_fe_adr <= w_adr;
      r_fe_exp <= w_lfsr;
      r_fe_act <= wb.wb_err_i ? 32'h0 : wb.wb_dat_i;
    end
  end

  assign first_err_adr_o = r_fe_adr;
  assign first_err_exp_o = r_fe_exp;
  assign first_err_act_o = r_fe_act;
`endif

  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == FIN);
  assign pass_o      = r_pass;
  assign timeout_o   = r_timeout;
  assign err_count_o = r_err;

  assign wb.wb_cyc_o = w_stb;
  assign wb.wb_stb_o = w_stb;
  assign wb.wb_we_o  = (r_state == WR);
  assign wb.wb_adr_o = w_stb ? w_adr : '0;
  assign wb.wb_sel_o = 4'hF;
  assign wb.wb_dat_o = (r_state == WR) ? w_lfsr : 32'h0;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Bench for wb_mem_tester: behavioural RAM slave with fault knobs, vector table plus directed sequences.
module tb_wb_mem_tester;
  import wb_mem_tester_pkg::*;

  localparam int          AW    = 32;
  localparam int          WORDS = 64;
  localparam int          TMO   = 8;
  localparam logic [31:0] SEED  = 32'hACE1_2345;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, tmo;
  logic [15:0] errc;

  wb_mem_tester_if #(.ADDR_WIDTH(AW)) wb_bus ();

`ifdef WB_MEM_TESTER_ERR_LOG_EN
  logic [AW-1:0] fe_adr;
  logic [31:0]   fe_exp, fe_act;
`endif

  wb_mem_tester #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  ('0),
    .WORDS      (WORDS),
    .TIMEOUT    (TMO),
    .SEED       (SEED)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .timeout_o   (tmo),
    .err_count_o (errc),
    .wb          (wb_bus)
`ifdef WB_MEM_TESTER_ERR_LOG_EN
    ,
    .first_err_adr_o (fe_adr),
    .first_err_exp_o (fe_exp),
    .first_err_act_o (fe_act)
`endif
  );

  always #5 clk = ~clk;

  // Slave knobs
  int k_wait = 0;
  bit k_corrupt = 0, k_ackerr = 0, k_noack = 0, k_stray = 0, k_fill = 0;

  logic [31:0] mem [0:255];
  int          wcnt = 0;
  logic        s_ack, s_err;

  always_comb begin
    s_ack = 1'b0;
    s_err = 1'b0;
    wb_bus.wb_dat_i = 32'h0;
    if (wb_bus.wb_stb_o && !k_noack && (wcnt == k_wait)) begin
      s_ack = 1'b1;
      s_err = k_ackerr && wb_bus.wb_we_o && (wb_bus.wb_adr_o == 32'h0C);
    end
    if (wb_bus.wb_stb_o && !wb_bus.wb_we_o)
      wb_bus.wb_dat_i = mem[wb_bus.wb_adr_o[9:2]] ^
                        ((k_corrupt && (wb_bus.wb_adr_o == 32'h10)) ? 32'h1 : 32'h0);
    wb_bus.wb_ack_i = s_ack || (k_stray && !wb_bus.wb_stb_o);
    wb_bus.wb_err_i = s_err || (k_stray && !wb_bus.wb_stb_o);
  end

  always @(posedge clk) begin
    if (k_fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hDEAD_BEEF;
    end else if (wb_bus.wb_stb_o && wb_bus.wb_we_o && s_ack) begin
      mem[wb_bus.wb_adr_o[9:2]] <= wb_bus.wb_dat_o;
    end
    if (wb_bus.wb_stb_o && !s_ack && !s_err) wcnt <= wcnt + 1;
    else                                     wcnt <= 0;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_pow(input int n);
    logic [31:0] v = SEED;
    for (int i = 0; i < n; i++) v = lfsr_next(v);
    return v;
  endfunction

  task automatic fill_mem();
    k_fill = 1'b1;
    @(negedge clk);
    k_fill = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic run_test(input int restart_at, output int ncyc, output int nstb,
                          output int nxfer, output int nviol, output int nwbad, output bit hung);
    logic        p_stb = 1'b0, p_fin = 1'b0, p_we = 1'b0;
    logic [31:0] p_adr = '0, p_dat = '0;
    logic [31:0] wexp = SEED;
    int          widx = 0;
    bit          got = 1'b0;
    ncyc = 1; nstb = 0; nxfer = 0; nviol = 0; nwbad = 0; hung = 1'b0;
    start = 1'b1;
    while (!got && ncyc < 4000) begin
      @(negedge clk);
      ncyc++;
      start = (restart_at >= 0) && (ncyc == restart_at + 1);
      if (wb_bus.wb_stb_o) begin
        nstb++;
        if (p_stb && !p_fin && (wb_bus.wb_adr_o != p_adr || wb_bus.wb_dat_o != p_dat ||
                                wb_bus.wb_we_o != p_we))
          nviol++;
        if (wb_bus.wb_ack_i || wb_bus.wb_err_i) begin
          nxfer++;
          if (wb_bus.wb_we_o) begin
            if (wb_bus.wb_dat_o != wexp || wb_bus.wb_adr_o != 32'(4 * widx)) nwbad++;
            wexp = lfsr_next(wexp);
            widx++;
          end
        end
      end
      p_stb = wb_bus.wb_stb_o;
      p_fin = wb_bus.wb_stb_o && (wb_bus.wb_ack_i || wb_bus.wb_err_i);
      p_we  = wb_bus.wb_we_o;
      p_adr = wb_bus.wb_adr_o;
      p_dat = wb_bus.wb_dat_o;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    hung = !got;
  endtask

  typedef struct {
    int wait_n;
    bit corrupt;
    bit ackerr;
    bit noack;
    bit stray;
    int exp_err;
    bit exp_pass;
    bit exp_tmo;
    int exp_cyc;
    int exp_stb;
    int exp_xfer;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int  ncyc, nstb, nxfer, nviol, nwbad, rd_wait;
    bit  hung;

    vecs[0] = '{0, 0, 0, 0, 0, 0, 1, 0, 258, 128, 128};  // clean, zero wait
    vecs[1] = '{0, 1, 0, 0, 0, 1, 0, 0, 258, 128, 128};  // bit0 flipped at 0x10
    vecs[2] = '{0, 0, 1, 0, 0, 1, 0, 0, 258, 128, 128};  // ACK+ERR on write 3
    vecs[3] = '{3, 0, 0, 0, 0, 0, 1, 0, 642, 512, 128};  // 3 wait states
    vecs[4] = '{0, 0, 0, 1, 0, 0, 0, 1,  10,   8,   0};  // never ACK -> timeout
    vecs[5] = '{0, 0, 0, 0, 1, 0, 1, 0, 258, 128, 128};  // stray ACK/ERR with STB low
    vecs[6] = '{1, 1, 0, 0, 1, 1, 0, 0, 386, 256, 128};  // 1 wait, corrupt, stray

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst pass", pass, 0);
    chk("rst timeout", tmo, 0);
    chk("rst err_count", errc, 0);
    chk("rst cyc", wb_bus.wb_cyc_o, 0);
    chk("rst stb", wb_bus.wb_stb_o, 0);
    chk("rst adr", wb_bus.wb_adr_o, 0);
    chk("rst dat_o", wb_bus.wb_dat_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      k_wait = vecs[v].wait_n;   k_corrupt = vecs[v].corrupt; k_ackerr = vecs[v].ackerr;
      k_noack = vecs[v].noack;   k_stray = vecs[v].stray;
      fill_mem();
      run_test(-1, ncyc, nstb, nxfer, nviol, nwbad, hung);
      chk($sformatf("v%0d done reached", v), hung, 0);
      chk($sformatf("v%0d cycles", v), ncyc, vecs[v].exp_cyc);
      chk($sformatf("v%0d stb cycles", v), nstb, vecs[v].exp_stb);
      chk($sformatf("v%0d transfers", v), nxfer, vecs[v].exp_xfer);
      chk($sformatf("v%0d stable", v), nviol, 0);
      chk($sformatf("v%0d write data", v), nwbad, 0);
      @(negedge clk);
      chk($sformatf("v%0d busy", v), busy, 0);
      chk($sformatf("v%0d err_count", v), errc, vecs[v].exp_err);
      chk($sformatf("v%0d pass", v), pass, vecs[v].exp_pass);
      chk($sformatf("v%0d timeout", v), tmo, vecs[v].exp_tmo);
`ifdef WB_MEM_TESTER_ERR_LOG_EN
      if (vecs[v].corrupt) begin
        chk($sformatf("v%0d fe_adr", v), fe_adr, 32'h10);
        chk($sformatf("v%0d fe_exp", v), fe_exp, lfsr_pow(4));
        chk($sformatf("v%0d fe_act", v), fe_act, lfsr_pow(4) ^ 32'h1);
      end else if (vecs[v].ackerr) begin
        chk($sformatf("v%0d fe_adr", v), fe_adr, 32'h0C);
        chk($sformatf("v%0d fe_exp", v), fe_exp, lfsr_pow(3));
        chk($sformatf("v%0d fe_act", v), fe_act, 0);
      end else begin
        chk($sformatf("v%0d fe_adr", v), fe_adr, 0);
        chk($sformatf("v%0d fe_exp", v), fe_exp, 0);
      end
`endif
    end

    // Second start while busy is ignored; start during FIN is ignored too
    k_wait = 0; k_corrupt = 0; k_ackerr = 0; k_noack = 0; k_stray = 0;
    fill_mem();
    run_test(20, ncyc, nstb, nxfer, nviol, nwbad, hung);
    chk("restart cycles", ncyc, 258);
    chk("restart transfers", nxfer, 128);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fin start busy", busy, 0);
    chk("fin start pass", pass, 1);
    @(negedge clk);
    chk("fin start idle", busy, 0);

    // First write beat, then reset in the middle of the read phase
    fill_mem();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wr0 dat", wb_bus.wb_dat_o, SEED);
    chk("wr0 adr", wb_bus.wb_adr_o, 0);
    chk("wr0 we", wb_bus.wb_we_o, 1);
    chk("wr0 sel", wb_bus.wb_sel_o, 4'hF);
    rd_wait = 0;
    while (!(wb_bus.wb_stb_o && !wb_bus.wb_we_o) && rd_wait < 300) begin
      @(negedge clk);
      rd_wait++;
    end
    chk("reach read", rd_wait < 300, 1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst cyc", wb_bus.wb_cyc_o, 0);
    chk("arst stb", wb_bus.wb_stb_o, 0);
    chk("arst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_mem();
    run_test(-1, ncyc, nstb, nxfer, nviol, nwbad, hung);
    chk("post rst cycles", ncyc, 258);
    @(negedge clk);
    chk("post rst pass", pass, 1);
    chk("post rst err_count", errc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_mem_tester.md
Name: wb_mem_tester

Overview:
- Synthesizable Wishbone classic master used for built-in self-test of Wishbone memory slaves such as wb_xpm_ram.
- On start, writes an LFSR-generated word pattern across a word-aligned address window, then reseeds the LFSR, reads the window back and compares each word.
- Reports pass/fail, mismatch count and bus timeout.
- Sits beside a RAM slave on the interconnect; driven by a control register block or a bench.

Parameters:
- ADDR_WIDTH, 32, Wishbone byte-address width.
- BASE_ADDR, 0, byte address of the first word; must be 4-aligned.
- WORDS, 64, number of 32-bit words tested; must be 1..2^16.
- TIMEOUT, 255, maximum cycles STB may wait for ACK/ERR before abort; must be >= 1.
- SEED, 32'hACE1_2345, LFSR seed; must be nonzero.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start pulse; ignored while busy_o=1.
- busy_o  out  1  test in progress.
- done_o  out  1  one-cycle pulse when the test ends.
- pass_o  out  1  valid after done: 1 when err_count_o=0 and timeout_o=0.
- timeout_o  out  1  last test aborted on bus timeout.
- err_count_o  out  16  mismatches and ERR responses, saturating at 16'hFFFF.
- wb_cyc_o  out  1  Wishbone CYC.
- wb_stb_o  out  1  Wishbone STB.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  ADDR_WIDTH  byte address.
- wb_sel_o  out  4  byte select; always 4'b1111.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  ACK.
- wb_err_i  in  1  ERR.

Behaviour:
- Reset: all outputs 0, state IDLE, LFSR=SEED.
- LFSR: 32-bit Galois, polynomial 32'h8020_0003, shifts right. It advances exactly once per completed transfer (ACK or ERR). The current value is the data for that word.
- FSM states:
  - IDLE: start_i -> clear err_count_o and timeout_o, load LFSR=SEED, index=0, set busy_o, go to WR.
  - WR: CYC=STB=WE=1, adr=BASE_ADDR+4*index, dat_o=LFSR, held stable until ACK or ERR. On ACK or ERR go to WGAP; ERR also increments err_count_o.
  - WGAP: one cycle with CYC=STB=0. If index=WORDS-1, reload LFSR=SEED, set index=0, go to RD. Otherwise index++ and go to WR.
  - RD: CYC=STB=1, WE=0. On ACK compare wb_dat_i with LFSR in the same cycle; on mismatch increment err_count_o. ERR also increments err_count_o. Then go to RGAP.
  - RGAP: same as WGAP, but at the last index go to FIN.
  - FIN: pulse done_o for one cycle, latch pass_o, clear busy_o, go to IDLE.
- Transfer timing: minimum 2 cycles per word (STB cycle plus gap). Total minimum 4*WORDS+2 cycles from start to done.
- ACK and ERR together: treated as ERR.
- ACK or ERR while STB=0: ignored.
- Timeout: a per-transfer counter clears when STB rises. If it reaches TIMEOUT with no ACK/ERR, drop CYC/STB, set timeout_o=1, go to FIN with pass_o=0.
- err_count_o never wraps.
- start_i during FIN is ignored. A new test may start from the next IDLE cycle.
- rst_ni low mid-transfer drops CYC/STB asynchronously and resets everything.
- Results (pass_o, timeout_o, err_count_o) hold until the next accepted start.

Optional Feature:
- Macro: WB_MEM_TESTER_ERR_LOG_EN.
- Defined: adds outputs first_err_adr_o (ADDR_WIDTH), first_err_exp_o (32) and first_err_act_o (32).
  - On the first read mismatch or ERR of a test, these capture address, expected LFSR value and wb_dat_i (0 for ERR).
  - Cleared on accepted start; 0 at reset.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package wb_mem_tester_pkg holds:
  - the state typedef enum {IDLE, WR, WGAP, RD, RGAP, FIN};
  - the constant LFSR_POLY=32'h8020_0003;
  - a function lfsr_next() for bench reuse.
- Sub-module lfsr32 (ports: clk_i, rst_ni, load_i, seed_i, adv_i, q_o). It is instantiated once; the bench uses the package function as its model.

Test Plan:
- wb_xpm_ram slave, WORDS=64, start pulse -> 64 writes then 64 reads; done after >=258 cycles; pass_o=1, err_count_o=0.
- Slave forcing bit 0 of read data at address 0x10 -> err_count_o=1, pass_o=0. With ERR_LOG_EN: first_err_adr_o=0x10, first_err_exp_o=lfsr_next^4(SEED).
- Slave never ACKs, TIMEOUT=8 -> STB high for exactly 8 cycles, then CYC=0; timeout_o=1, pass_o=0, done pulse.
- Slave asserts ACK and ERR together on write 3 -> err_count_o=1 and the test completes all 2*WORDS transfers.
- Second start_i while busy, then rst_ni low mid-read -> the second start is ignored; on reset CYC/STB/busy go low immediately and the next start runs a clean pass.
- Slave with 3-cycle ACK wait states -> adr and dat_o stay stable while STB=1; pass_o=1.
